// File: rtl/otter_io_pkg.sv
// Shared constants and types for the OTTER board input path.
// Debounce timing derives from the system clock rate; button indices are consumed by the wrapper.
package otter_io_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 10;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int DB_CYCLES_DEFAULT = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);

  localparam int NUM_BTN    = 5;
  localparam int BTN_CENTER = 0;
  localparam int BTN_UP     = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RESET  = 3;
  localparam int BTN_DOWN   = 4;

  typedef struct packed {
    logic db;
    logic rise;
    logic fall;
    logic pending;
  } ch_status_t;

endpackage

// File: rtl/otter_input_conditioner_if.sv
// Pin-side inputs and conditioned outputs of the input conditioner.
// master = board/consumer side, slave = conditioner.
interface otter_input_conditioner_if #(parameter int NUM_CH = 5);

  logic [NUM_CH-1:0] raw_in;
  logic [NUM_CH-1:0] db_out;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic              busy;

  modport master (output raw_in, input db_out, input rise, input fall, input busy);
  modport slave  (input raw_in, output db_out, output rise, output fall, output busy);

endinterface

// File: rtl/otter_debounce_ch.sv
// One input channel: synchroniser chain, stability counter, debounced level and edge strobes.
// A change is accepted after DB_CYCLES consecutive cycles of disagreement at the sync output.
module otter_debounce_ch
  import otter_io_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter logic RESET_BIT   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  output ch_status_t st
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   db_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_BIT}};
      cnt_q  <= '0;
      db_q   <= RESET_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      // Any return to the accepted level restarts the stability window.
      if (s == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        db_q   <= s;
        cnt_q  <= '0;
        rise_q <= s;
        fall_q <= ~s;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign st = '{db: db_q, rise: rise_q, fall: fall_q, pending: s ^ db_q};

endmodule

// File: rtl/otter_input_conditioner.sv
// N independent debounced input channels with rise/fall strobes.
// busy is high while any channel has a change pending acceptance.
module otter_input_conditioner
  import otter_io_pkg::*;
#(
  parameter int                NUM_CH      = 5,
  parameter int                SYNC_STAGES = 2,
  parameter int                DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter logic [NUM_CH-1:0] RESET_VAL   = '0
) (
  input logic                      clk,
  input logic                      rst,
  otter_input_conditioner_if.slave io
);

  ch_status_t        st [NUM_CH];
  logic [NUM_CH-1:0] db_vec;
  logic [NUM_CH-1:0] rise_vec;
  logic [NUM_CH-1:0] fall_vec;
  logic [NUM_CH-1:0] pend_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    otter_debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .RESET_BIT   (RESET_VAL[i])
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .raw (io.raw_in[i]),
      .st  (st[i])
    );

    assign db_vec[i]   = st[i].db;
    assign rise_vec[i] = st[i].rise;
    assign fall_vec[i] = st[i].fall;
    assign pend_vec[i] = st[i].pending;
  end

  assign io.db_out = db_vec;
  assign io.rise   = rise_vec;
  assign io.fall   = fall_vec;
  assign io.busy   = |pend_vec;

endmodule

// File: tb/tb_otter_input_conditioner.sv
// Directed bench for otter_input_conditioner with a cycle-tagged expectation scoreboard.
module tb_otter_input_conditioner;

  logic clk = 1'b0;
  logic rst;
  int   edge_n = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #10 clk = ~clk;
  always @(posedge clk) edge_n++;

  otter_input_conditioner_if #(.NUM_CH(5)) io ();

  otter_input_conditioner #(
    .NUM_CH      (5),
    .SYNC_STAGES (2),
    .DB_CYCLES   (4),
    .RESET_VAL   (5'b00000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  typedef struct {
    int         cyc;
    logic [4:0] db;
    logic [4:0] rise;
    logic [4:0] fall;
    logic       busy;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  task automatic push(input int cyc, input logic [4:0] db, input logic [4:0] r,
                      input logic [4:0] f, input logic b, input string name);
    exp_t x;
    x.cyc = cyc; x.db = db; x.rise = r; x.fall = f; x.busy = b; x.name = name;
    sb.push_back(x);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: outputs observed on the falling edge after edge edge_n.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc < edge_n) begin
        n_fail++;
        $display("FAIL %s: expectation for edge %0d not observed (now edge %0d)", e.name, e.cyc, edge_n);
      end else if ({io.db_out, io.rise, io.fall, io.busy} !== {e.db, e.rise, e.fall, e.busy}) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got db=%b rise=%b fall=%b busy=%b, want db=%b rise=%b fall=%b busy=%b",
                 e.name, edge_n, io.db_out, io.rise, io.fall, io.busy, e.db, e.rise, e.fall, e.busy);
      end
    end
    if (edge_n >= 1) begin
      n_checks++;
      if ((io.rise & io.fall) !== 5'b00000) begin
        n_fail++;
        $display("FAIL rise_fall_overlap @edge %0d: got rise&fall=%b, want 00000", edge_n, io.rise & io.fall);
      end
    end
  end

  initial begin
    int b;
    logic bz;

    // 1: reset with all inputs high
    rst = 1'b1;
    io.raw_in = 5'b11111;
    wait_edges(1);
    rst = 1'b0;
    io.raw_in = 5'b00000;
    push(1, 5'b00000, 5'b00000, 5'b00000, 1'b0, "reset_state");
    push(3, 5'b00000, 5'b00000, 5'b00000, 1'b0, "reset_idle");
    wait_edges(3);

    // 2: clean press on channel 3
    b = edge_n;
    io.raw_in = 5'b01000;
    push(b + 1, 5'b00000, 5'b00000, 5'b00000, 1'b0, "press_sync");
    push(b + 2, 5'b00000, 5'b00000, 5'b00000, 1'b1, "press_busy");
    push(b + 5, 5'b00000, 5'b00000, 5'b00000, 1'b1, "press_not_yet");
    push(b + 6, 5'b01000, 5'b01000, 5'b00000, 1'b0, "press_accept");
    push(b + 7, 5'b01000, 5'b00000, 5'b00000, 1'b0, "press_strobe_end");
    wait_edges(8);

    // 5: release channel 3
    b = edge_n;
    io.raw_in = 5'b00000;
    push(b + 2, 5'b01000, 5'b00000, 5'b00000, 1'b1, "release_busy");
    push(b + 5, 5'b01000, 5'b00000, 5'b00000, 1'b1, "release_not_yet");
    push(b + 6, 5'b00000, 5'b00000, 5'b01000, 1'b0, "release_accept");
    push(b + 7, 5'b00000, 5'b00000, 5'b00000, 1'b0, "release_strobe_end");
    wait_edges(8);

    // 3: bounce on channel 0, 2-cycle toggles then hold high
    b = edge_n;
    for (int k = 1; k <= 13; k++) begin
      if (k < 2) bz = 1'b0;
      else if (k >= 10) bz = 1'b1;
      else bz = (((k - 2) / 2) % 2 == 0);
      push(b + k, 5'b00000, 5'b00000, 5'b00000, bz, "bounce_quiet");
    end
    push(b + 14, 5'b00001, 5'b00001, 5'b00000, 1'b0, "bounce_accept");
    push(b + 15, 5'b00001, 5'b00000, 5'b00000, 1'b0, "bounce_strobe_end");
    io.raw_in = 5'b00001;
    wait_edges(2);
    io.raw_in = 5'b00000;
    wait_edges(2);
    io.raw_in = 5'b00001;
    wait_edges(2);
    io.raw_in = 5'b00000;
    wait_edges(2);
    io.raw_in = 5'b00001;
    wait_edges(8);

    // release channel 0
    b = edge_n;
    io.raw_in = 5'b00000;
    push(b + 5, 5'b00001, 5'b00000, 5'b00000, 1'b1, "rel0_not_yet");
    push(b + 6, 5'b00000, 5'b00000, 5'b00001, 1'b0, "rel0_accept");
    push(b + 7, 5'b00000, 5'b00000, 5'b00000, 1'b0, "rel0_strobe_end");
    wait_edges(8);

    // 4: parallel press on channels 4, 2, 0
    b = edge_n;
    io.raw_in = 5'b10101;
    push(b + 5, 5'b00000, 5'b00000, 5'b00000, 1'b1, "par_not_yet");
    push(b + 6, 5'b10101, 5'b10101, 5'b00000, 1'b0, "par_accept");
    push(b + 7, 5'b10101, 5'b00000, 5'b00000, 1'b0, "par_strobe_end");
    wait_edges(8);

    // parallel release
    b = edge_n;
    io.raw_in = 5'b00000;
    push(b + 6, 5'b00000, 5'b00000, 5'b10101, 1'b0, "par_rel_accept");
    push(b + 7, 5'b00000, 5'b00000, 5'b00000, 1'b0, "par_rel_strobe_end");
    wait_edges(8);

    // 6: reset in the middle of a count on channel 1
    b = edge_n;
    io.raw_in = 5'b00010;
    push(b + 2,  5'b00000, 5'b00000, 5'b00000, 1'b1, "midrst_busy");
    push(b + 3,  5'b00000, 5'b00000, 5'b00000, 1'b1, "midrst_counting");
    push(b + 4,  5'b00000, 5'b00000, 5'b00000, 1'b0, "midrst_cleared");
    push(b + 5,  5'b00000, 5'b00000, 5'b00000, 1'b0, "midrst_resync");
    push(b + 6,  5'b00000, 5'b00000, 5'b00000, 1'b1, "midrst_busy_again");
    push(b + 9,  5'b00000, 5'b00000, 5'b00000, 1'b1, "midrst_not_yet");
    push(b + 10, 5'b00010, 5'b00010, 5'b00000, 1'b0, "midrst_accept");
    push(b + 11, 5'b00010, 5'b00000, 5'b00000, 1'b0, "midrst_strobe_end");
    wait_edges(3);
    rst = 1'b1;
    wait_edges(1);
    rst = 1'b0;
    wait_edges(9);

    wait_edges(2);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for edge %0d left unchecked", e.name, e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
